pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures high time and period of an incoming
//  PWM waveform in clk cycles. Used for loopback checking of the generator and for capturing

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_capture_if.sv | 29 ++
 rtl/pwm_capture_sync_2ff.sv | 22 ++
 rtl/pwm_capture.sv | 146 ++++++++++++++
 tb/tb_pwm_capture.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM constants and capture FSM state encoding.
// Used by the PWM generator, the capture block and their benches.
package pwm_pkg;

    localparam int CLK_FREQ   = 50_000_000;
    localparam int PWM_FREQ   = 10_000;
    localparam int PERIOD_VAL = CLK_FREQ / PWM_FREQ;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bundle of the PWM capture block.
// master: capture drives duty/period/valid/stuck; slave: consumer.
interface pwm_capture_if #(
    parameter int CNT_W = 15
);

    logic [CNT_W-1:0] duty_meas;
    logic [CNT_W-1:0] period_meas;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;

    modport master (
        output duty_meas,
        output period_meas,
        output meas_valid,
        output stuck_high,
        output stuck_low
    );

    modport slave (
        input duty_meas,
        input period_meas,
        input meas_valid,
        input stuck_high,
        input stuck_low
    );

endinterface

// File: rtl/pwm_capture_sync_2ff.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period in clk cycles.
// Ports: clk, rst_n, pwm_in (async), meas (duty/period/valid/stuck flags).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CLK_FREQ    = pwm_pkg::CLK_FREQ,
    parameter int PWM_FREQ    = pwm_pkg::PWM_FREQ,
    parameter int PERIOD_VAL  = CLK_FREQ / PWM_FREQ,
    parameter int TIMEOUT_CYC = 2 * PERIOD_VAL,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    pwm_capture_if.master meas
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t TMO_MAX = cnt_t'(TIMEOUT_CYC);
    localparam cnt_t TMO_M1  = cnt_t'(TIMEOUT_CYC - 1);
    localparam cnt_t ONE     = cnt_t'(1);

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + ONE;
    endfunction

    logic       s2;
    logic       s3;
    logic       rise;
    logic       fall;
    logic       tmo_hit;
    logic       latch;

    cap_state_t state_q;
    cap_state_t state_d;
    cnt_t       hi_q;
    cnt_t       hi_d;
    cnt_t       per_q;
    cnt_t       per_d;
    cnt_t       tmo_q;

    cnt_t       duty_q;
    cnt_t       period_q;
    logic       valid_q;
    logic       sh_q;
    logic       sl_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3 <= 1'b0;
        else        s3 <= s2;
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Fires once per stuck interval: the counter parks at TMO_MAX.
    // An edge in the same cycle clears the counter and wins.
    assign tmo_hit = (tmo_q == TMO_M1) && !(rise || fall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              tmo_q <= '0;
        else if (rise || fall)   tmo_q <= '0;
        else if (tmo_q != TMO_MAX) tmo_q <= tmo_q + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            per_q   <= per_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        per_d   = per_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hi_d    = ONE;
                    per_d   = ONE;
                end
            end
            HIGH: begin
                per_d = sat_inc(per_q);
                if (fall) state_d = LOW;
                else      hi_d    = sat_inc(hi_q);
            end
            LOW: begin
                if (rise) begin
                    latch   = 1'b1;
                    state_d = HIGH;
                    hi_d    = ONE;
                    per_d   = ONE;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            sh_q     <= 1'b0;
            sl_q     <= 1'b0;
        end else begin
            valid_q <= latch;
            if (latch) begin
                duty_q   <= hi_q;
                period_q <= per_q;
                sh_q     <= 1'b0;
                sl_q     <= 1'b0;
            end else if (tmo_hit) begin
                sh_q <= s2;
                sl_q <= ~s2;
            end
        end
    end

    assign meas.duty_meas   = duty_q;
    assign meas.period_meas = period_q;
    assign meas.meas_valid  = valid_q;
    assign meas.stuck_high  = sh_q;
    assign meas.stuck_low   = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: vector table, hand corner cases, random model.
// Scaled clock/PWM ratio: period 100, timeout 200 cycles.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int TCLK = 1_000_000;
    localparam int TPWM = 10_000;
    localparam int TP   = TCLK / TPWM;
    localparam int TMO  = 2 * TP;
    localparam int TW   = $clog2(TMO) + 1;

    typedef struct {
        int hi;
        int lo;
        int exp_duty;
        int exp_period;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_in = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    int got_d[$];
    int got_p[$];
    int seg_lvl[$];
    int seg_len[$];
    int exp_d[$];
    int exp_p[$];

    vec_t vecs[10];

    pwm_capture_if #(.CNT_W(TW)) m ();

    pwm_capture #(
        .CLK_FREQ    (TCLK),
        .PWM_FREQ    (TPWM),
        .PERIOD_VAL  (TP),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (TW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .meas   (m)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (m.meas_valid) begin
            got_d.push_back(int'(m.duty_meas));
            got_p.push_back(int'(m.period_meas));
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic seg(input int lvl, input int len);
        pwm_in = lvl[0];
        seg_lvl.push_back(lvl);
        seg_len.push_back(len);
        repeat (len) @(negedge clk);
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        got_d.delete();
        got_p.delete();
        seg_lvl.delete();
        seg_len.delete();
        rst_n = 1'b1;
    endtask

    // Expected reports and final flags from the waveform's segment list:
    // a period is reported at the next rise if no level inside it lasted
    // beyond the timeout; a level held longer than the timeout flags stuck.
    task automatic model(output int sh, output int sl);
        int armed;
        int hi;
        int lo;
        armed = 0;
        hi = 0;
        lo = 0;
        sh = 0;
        sl = 0;
        exp_d.delete();
        exp_p.delete();
        for (int i = 0; i < seg_lvl.size(); i++) begin
            if (seg_lvl[i] == 1) begin
                if (armed == 1) begin
                    exp_d.push_back(hi);
                    exp_p.push_back(hi + lo);
                    sh = 0;
                    sl = 0;
                end
                armed = 1;
                hi = seg_len[i];
            end else begin
                lo = seg_len[i];
            end
            if (seg_len[i] > TMO) begin
                armed = 0;
                sh = seg_lvl[i];
                sl = 1 - seg_lvl[i];
            end
        end
    endtask

    task automatic cmp_reports(input string tag);
        check({tag, " count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            check($sformatf("%s duty[%0d]", tag, i),
                  (i < got_d.size()) ? got_d[i] : -1, exp_d[i]);
            check($sformatf("%s period[%0d]", tag, i),
                  (i < got_p.size()) ? got_p[i] : -1, exp_p[i]);
        end
    endtask

    initial begin
        int sh;
        int sl;
        int n0;
        int r;
        int h;
        int l;

        vecs[0] = '{2, 98, 2, 100};
        vecs[1] = '{2, 98, 2, 100};
        vecs[2] = '{2, 98, 2, 100};
        vecs[3] = '{2, 98, 2, 100};
        vecs[4] = '{50, 50, 50, 100};
        vecs[5] = '{50, 50, 50, 100};
        vecs[6] = '{1, 99, 1, 100};
        vecs[7] = '{99, 1, 99, 100};
        vecs[8] = '{20, 180, 20, 200};
        vecs[9] = '{30, TMO, 30, 30 + TMO};

        // Reset state
        #25;
        check("rst duty", int'(m.duty_meas), 0);
        check("rst period", int'(m.period_meas), 0);
        check("rst valid", int'(m.meas_valid), 0);
        check("rst stuck_high", int'(m.stuck_high), 0);
        check("rst stuck_low", int'(m.stuck_low), 0);

        // Held low after release: stuck_low at exactly TMO cycles
        do_reset();
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("stuck_low early", int'(m.stuck_low), 0);
        @(posedge clk);
        #1;
        check("stuck_low on time", int'(m.stuck_low), 1);
        check("stuck_high excl", int'(m.stuck_high), 0);
        check("no valid when stuck", got_d.size(), 0);
        @(negedge clk);
        seg(1, 50);
        seg(0, 50);
        check("stuck_low held", int'(m.stuck_low), 1);
        check("no valid 1st rise", got_d.size(), 0);
        seg(1, 10);
        check("stuck_low cleared", int'(m.stuck_low), 0);
        check("recov count", got_d.size(), 1);
        check("recov duty", int'(m.duty_meas), 50);
        check("recov period", int'(m.period_meas), 100);

        // Vector table: every period reported at the following rise
        do_reset();
        seg(0, 20);
        foreach (vecs[i]) begin
            seg(1, vecs[i].hi);
            seg(0, vecs[i].lo);
        end
        seg(1, 10);
        check("tbl count", got_d.size(), 10);
        foreach (vecs[i]) begin
            check($sformatf("tbl duty[%0d]", i),
                  (i < got_d.size()) ? got_d[i] : -1, vecs[i].exp_duty);
            check($sformatf("tbl period[%0d]", i),
                  (i < got_p.size()) ? got_p[i] : -1, vecs[i].exp_period);
        end
        check("tbl stuck_low", int'(m.stuck_low), 0);
        check("tbl stuck_high", int'(m.stuck_high), 0);

        // Stuck high mid-stream, outputs hold, then recover
        do_reset();
        seg(0, 20);
        seg(1, 30);
        seg(0, 70);
        seg(1, 30);
        seg(0, 70);
        pwm_in = 1'b1;
        repeat (TMO + 2) @(posedge clk);
        #1;
        check("stuck_high early", int'(m.stuck_high), 0);
        @(posedge clk);
        #1;
        check("stuck_high on time", int'(m.stuck_high), 1);
        check("stuck_low excl", int'(m.stuck_low), 0);
        check("hold duty", int'(m.duty_meas), 30);
        check("hold period", int'(m.period_meas), 100);
        @(negedge clk);
        repeat (20) @(negedge clk);
        seg(0, 50);
        seg(1, 50);
        seg(0, 50);
        check("stuck_high held", int'(m.stuck_high), 1);
        check("sh count before", got_d.size(), 2);
        seg(1, 10);
        check("stuck_high cleared", int'(m.stuck_high), 0);
        check("sh recov duty", int'(m.duty_meas), 50);
        check("sh recov period", int'(m.period_meas), 100);

        // Async reset while in HIGH
        #3;
        rst_n = 1'b0;
        #1;
        check("async duty", int'(m.duty_meas), 0);
        check("async period", int'(m.period_meas), 0);
        check("async valid", int'(m.meas_valid), 0);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n0 = got_d.size();
        seg(0, 20);
        seg(1, 40);
        seg(0, 60);
        check("post rst no valid", got_d.size(), n0);
        seg(1, 10);
        check("post rst 2nd rise", got_d.size(), n0 + 1);
        check("post rst duty", int'(m.duty_meas), 40);
        check("post rst period", int'(m.period_meas), 100);

        // Random waveform against segment model
        do_reset();
        seg(0, 20);
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            h = (r == 0) ? $urandom_range(TMO + 1, TMO + 40)
              : (r == 1) ? TMO : $urandom_range(1, 150);
            r = $urandom_range(0, 9);
            l = (r == 0) ? $urandom_range(TMO + 1, TMO + 40)
              : (r == 1) ? TMO : $urandom_range(1, 150);
            seg(1, h);
            seg(0, l);
        end
        seg(1, 10);
        model(sh, sl);
        cmp_reports("rnd");
        check("rnd stuck_high", int'(m.stuck_high), sh);
        check("rnd stuck_low", int'(m.stuck_low), sl);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
